control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired Moore control sequencer for the 32-bit datapath.
- Takes the IR contents and a memory-ready strobe from the datapath.
- Drives every datapath strobe (bus-out selects, register-in enables, IncPC, Read, ALU op), sequencing fetch (T0-T2) and register-register ALU execute (T3-T6).
- Replaces the hand-sequenced control stimulus used today in the datapath benches.

Parameters:
- OPW, 5, opcode width (IR[31:27])
- REGW, 4, register field width

Ports:
- Clock  in  1  system clock, rising edge
- Clear  in  1  reset, synchronous, active-high
- IR  in  32  instruction register. Opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15]
- MemRdy  in  1  memory read data valid on Mdatain this cycle
- Stop  in  1  halt request, sampled at T0 entry
- PCout, Zhighout, Zlowout, MDRout  out  1 each  bus source selects
- MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load enables
- IncPC, Read  out  1 each
- Gra, Grb, Grc, Rin, Rout  out  1 each  select-and-encode controls for the general-register file
- ALU_op  out  5  opcode presented to the ALU; valid whenever Zin=1, 0 otherwise
- Run  out  1  high unless halted

Behaviour:
- Opcodes:
  - ADD=00001, SUB=00010, AND=00011, OR=00100, SHR=00101, SHL=00110 (class ALU3)
  - MUL=01111, DIV=10000 (class HILO)
  - NOP=11010, HALT=11011
  - Any other opcode is executed as NOP.
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALTED. Encoded in the package.
- Outputs are decoded from the registered state plus IR only (Moore). No output depends on MemRdy or Stop combinationally.
- Clear=1 at a rising edge forces state RST next cycle, including mid-instruction or while HALTED.
  - In RST all outputs = 0 except Run=1.
  - RST -> T0 unconditionally.
- T0: PCout, MARin, IncPC, Zin = 1 (Z <= PC+1).
  - Next state is HALTED if Stop=1, else T1.
- T1: Zlowout, PCin, Read, MDRin = 1.
  - Remains in T1 while MemRdy=0; repeated PCin is idempotent.
  - MemRdy=1 -> T2.
- T2: MDRout, IRin = 1.
  - Next: T3 for ALU3/HILO classes.
  - T0 for NOP or illegal opcodes.
  - HALTED for HALT.
- T3: Grb, Rout, Yin = 1.
- T4: Grc, Rout, Zin = 1, ALU_op = IR[31:27].
- T5:
  - ALU3: Zlowout, Gra, Rin = 1, then next state T0.
  - HILO: Zlowout, LOin = 1, then next state T6.
- T6 (HILO only): Zhighout, HIin = 1, then next state T0.
- HALTED: all outputs 0, Run=0. Exits only through Clear.
- Instruction latency, counted from T0 entry to the next T0 with MemRdy high in the first T1 cycle:
  - ALU3: 6 cycles
  - HILO: 7 cycles
  - NOP: 3 cycles
  - Each extra wait cycle in T1 adds 1.
- At most one bus source select (PCout, Zhighout, Zlowout, MDRout, Rout) is high in any cycle. The bench checks this as an assertion.
- Stop asserted mid-instruction takes effect at the next T0. Stop and Clear together: Clear wins.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_ADD ... OP_HALT)
  - state encodings (ST_RST ... ST_HALTED)
  - IR field bit positions
- One sub-module: opcode_class. It is combinational and maps IR[31:27] to the one-hot class {alu3, hilo, nop, halt}, with illegal opcodes mapped to nop. It is reused later by the branch/load decoder.

Test Plan:
- Clear held 2 cycles, then released; IR=32'h1A920000 (AND R5,R2,R4); MemRdy tied 1 -> state sequence RST, T0, T1, T2, T3, T4, T5, T0. In T3 Grb=1 and Rout=1. In T4 Grc=1 and ALU_op=5'b00011. In T5 Gra=1 and Rin=1.
- IR=32'h7A920000 (MUL), MemRdy=1 -> T5 asserts LOin with Zlowout. T6 asserts HIin with Zhighout. Return to T0 after 7 cycles.
- MemRdy low for 3 cycles in T1 -> Read=1 and MDRin=1 held for 4 cycles, IRin pulses only once, and total ALU instruction time is 9 cycles.
- IR opcode 11011 (HALT) -> after T2, Run=0 and all strobes are 0 for 20 cycles. Clear -> RST then T0 with Run=1.
- IR opcode 10110 (illegal) -> T0, T1, T2, T0 with no Yin, Zin (beyond T0) or Rin asserted.
- Clear asserted during T4 -> next cycle is RST with all strobes 0. Stop=1 at T0 entry -> HALTED instead of T1. One-hot bus-source assertion holds throughout.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcodes, IR field positions,
// sequencer state encodings and the control-strobe bundle.
package cpu_pkg;

  localparam int IRW  = 32;
  localparam int OPW  = 5;
  localparam int REGW = 4;

  // IR field bit positions
  localparam int OP_HI = IRW - 1;
  localparam int OP_LO = IRW - OPW;
  localparam int RA_HI = OP_LO - 1;
  localparam int RA_LO = OP_LO - REGW;
  localparam int RB_HI = RA_LO - 1;
  localparam int RB_LO = RA_LO - REGW;
  localparam int RC_HI = RB_LO - 1;
  localparam int RC_LO = RB_LO - REGW;

  // Opcodes
  localparam logic [OPW-1:0] OP_ADD  = 5'b00001;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00010;
  localparam logic [OPW-1:0] OP_AND  = 5'b00011;
  localparam logic [OPW-1:0] OP_OR   = 5'b00100;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPW-1:0] OP_SHL  = 5'b00110;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_HALTED = 4'd8
  } state_t;

  // One-hot instruction class
  typedef struct packed {
    logic alu3;
    logic hilo;
    logic nop;
    logic halt;
  } op_class_t;

  // Every strobe the sequencer drives into the datapath
  typedef struct packed {
    logic           pc_out;
    logic           zhigh_out;
    logic           zlow_out;
    logic           mdr_out;
    logic           mar_in;
    logic           pc_in;
    logic           mdr_in;
    logic           ir_in;
    logic           y_in;
    logic           z_in;
    logic           hi_in;
    logic           lo_in;
    logic           inc_pc;
    logic           read;
    logic           gra;
    logic           grb;
    logic           grc;
    logic           r_in;
    logic           r_out;
    logic           run;
    logic [OPW-1:0] alu_op;
  } ctrl_t;

  function automatic logic [OPW-1:0] ir_opcode(input logic [IRW-1:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR/status in, all control strobes out.
interface control_unit_if;
  logic [31:0] IR;
  logic        MemRdy;
  logic        Stop;
  logic        PCout, Zhighout, Zlowout, MDRout;
  logic        MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic        IncPC, Read;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic [4:0]  ALU_op;
  logic        Run;

  modport master (
    input  IR, MemRdy, Stop,
    output PCout, Zhighout, Zlowout, MDRout,
    output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
    output IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALU_op, Run
  );

  modport slave (
    output IR, MemRdy, Stop,
    input  PCout, Zhighout, Zlowout, MDRout,
    input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
    input  IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALU_op, Run
  );
endinterface

// File: rtl/control_unit_opcode_class.sv
// Maps an opcode to its one-hot execution class; unknown opcodes run as NOP.
module opcode_class
  import cpu_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output op_class_t      op_class
);

  // Pure decode of the opcode field into a class
  always_comb begin
    op_class = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: op_class.alu3 = 1'b1;
      OP_MUL, OP_DIV:                                op_class.hilo = 1'b1;
      OP_HALT:                                       op_class.halt = 1'b1;
      default:                                       op_class.nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch (T0-T2) and register-register execute
// (T3-T6). Strobes are registered alongside the state they belong to.
module control_unit
  import cpu_pkg::*;
(
  input  logic           Clock,
  input  logic           Clear,
  control_unit_if.master cu
);

  logic [OPW-1:0] opcode;
  op_class_t      op_class;
  state_t         state, state_nxt;
  ctrl_t          ctrl;

  assign opcode = ir_opcode(cu.IR);

  opcode_class u_opcode_class (
    .opcode   (opcode),
    .op_class (op_class)
  );

  // Strobe pattern for a given state; IR only matters in T4/T5
  function automatic ctrl_t decode(input state_t s, input op_class_t c,
                                   input logic [OPW-1:0] op);
    ctrl_t d;
    d = '0;
    d.run = 1'b1;
    case (s)
      ST_RST: ;
      ST_T0: begin
        d.pc_out = 1'b1; d.mar_in = 1'b1; d.inc_pc = 1'b1; d.z_in = 1'b1;
      end
      ST_T1: begin
        d.zlow_out = 1'b1; d.pc_in = 1'b1; d.read = 1'b1; d.mdr_in = 1'b1;
      end
      ST_T2: begin
        d.mdr_out = 1'b1; d.ir_in = 1'b1;
      end
      ST_T3: begin
        d.grb = 1'b1; d.r_out = 1'b1; d.y_in = 1'b1;
      end
      ST_T4: begin
        d.grc = 1'b1; d.r_out = 1'b1; d.z_in = 1'b1; d.alu_op = op;
      end
      ST_T5: begin
        d.zlow_out = 1'b1;
        if (c.hilo) d.lo_in = 1'b1;
        else begin
          d.gra = 1'b1; d.r_in = 1'b1;
        end
      end
      ST_T6: begin
        d.zhigh_out = 1'b1; d.hi_in = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  // Next-state selection from the current state and sampled inputs
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:    state_nxt = ST_T0;
      ST_T0:     state_nxt = cu.Stop ? ST_HALTED : ST_T1;
      ST_T1:     state_nxt = cu.MemRdy ? ST_T2 : ST_T1;
      ST_T2: begin
        if (op_class.halt)                      state_nxt = ST_HALTED;
        else if (op_class.alu3 | op_class.hilo) state_nxt = ST_T3;
        else                                    state_nxt = ST_T0;
      end
      ST_T3:     state_nxt = ST_T4;
      ST_T4:     state_nxt = ST_T5;
      ST_T5:     state_nxt = op_class.hilo ? ST_T6 : ST_T0;
      ST_T6:     state_nxt = ST_T0;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RST;
    endcase
  end

  // State and strobe registers; Clear overrides everything, including HALTED
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state <= ST_RST;
      ctrl  <= decode(ST_RST, op_class, opcode);
    end else begin
      state <= state_nxt;
      ctrl  <= decode(state_nxt, op_class, opcode);
    end
  end

  assign cu.PCout    = ctrl.pc_out;
  assign cu.Zhighout = ctrl.zhigh_out;
  assign cu.Zlowout  = ctrl.zlow_out;
  assign cu.MDRout   = ctrl.mdr_out;
  assign cu.MARin    = ctrl.mar_in;
  assign cu.PCin     = ctrl.pc_in;
  assign cu.MDRin    = ctrl.mdr_in;
  assign cu.IRin     = ctrl.ir_in;
  assign cu.Yin      = ctrl.y_in;
  assign cu.Zin      = ctrl.z_in;
  assign cu.HIin     = ctrl.hi_in;
  assign cu.LOin     = ctrl.lo_in;
  assign cu.IncPC    = ctrl.inc_pc;
  assign cu.Read     = ctrl.read;
  assign cu.Gra      = ctrl.gra;
  assign cu.Grb      = ctrl.grb;
  assign cu.Grc      = ctrl.grc;
  assign cu.Rin      = ctrl.r_in;
  assign cu.Rout     = ctrl.r_out;
  assign cu.Run      = ctrl.run;
  assign cu.ALU_op   = ctrl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: vector table through a scoreboard, plus a
// hand-written memory-wait sequence.
module tb_control_unit;

  logic Clock = 1'b0;
  logic Clear = 1'b1;

  always #5 Clock = ~Clock;

  control_unit_if cu ();

  control_unit dut (
    .Clock (Clock),
    .Clear (Clear),
    .cu    (cu)
  );

  // Output vector layout: {PCout,Zhighout,Zlowout,MDRout,MARin,PCin,MDRin,IRin,
  //   Yin,Zin,HIin,LOin,IncPC,Read,Gra,Grb,Grc,Rin,Rout,Run,ALU_op[4:0]}
  localparam logic [24:0] M_PCOUT  = 25'd1 << 24;
  localparam logic [24:0] M_ZHIGH  = 25'd1 << 23;
  localparam logic [24:0] M_ZLOW   = 25'd1 << 22;
  localparam logic [24:0] M_MDROUT = 25'd1 << 21;
  localparam logic [24:0] M_MARIN  = 25'd1 << 20;
  localparam logic [24:0] M_PCIN   = 25'd1 << 19;
  localparam logic [24:0] M_MDRIN  = 25'd1 << 18;
  localparam logic [24:0] M_IRIN   = 25'd1 << 17;
  localparam logic [24:0] M_YIN    = 25'd1 << 16;
  localparam logic [24:0] M_ZIN    = 25'd1 << 15;
  localparam logic [24:0] M_HIIN   = 25'd1 << 14;
  localparam logic [24:0] M_LOIN   = 25'd1 << 13;
  localparam logic [24:0] M_INCPC  = 25'd1 << 12;
  localparam logic [24:0] M_READ   = 25'd1 << 11;
  localparam logic [24:0] M_GRA    = 25'd1 << 10;
  localparam logic [24:0] M_GRB    = 25'd1 << 9;
  localparam logic [24:0] M_GRC    = 25'd1 << 8;
  localparam logic [24:0] M_RIN    = 25'd1 << 7;
  localparam logic [24:0] M_ROUT   = 25'd1 << 6;
  localparam logic [24:0] M_RUN    = 25'd1 << 5;

  localparam logic [24:0] E_RST  = M_RUN;
  localparam logic [24:0] E_T0   = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
  localparam logic [24:0] E_T1   = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [24:0] E_T2   = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [24:0] E_T3   = M_GRB | M_ROUT | M_YIN | M_RUN;
  localparam logic [24:0] E_T4   = M_GRC | M_ROUT | M_ZIN | M_RUN;
  localparam logic [24:0] E_T5A  = M_ZLOW | M_GRA | M_RIN | M_RUN;
  localparam logic [24:0] E_T5H  = M_ZLOW | M_LOIN | M_RUN;
  localparam logic [24:0] E_T6   = M_ZHIGH | M_HIIN | M_RUN;
  localparam logic [24:0] E_HALT = 25'd0;

  localparam logic [31:0] IR_AND  = 32'h1A920000;
  localparam logic [31:0] IR_SUB  = 32'h10000000;
  localparam logic [31:0] IR_SHL  = 32'h30000000;
  localparam logic [31:0] IR_MUL  = 32'h7A920000;
  localparam logic [31:0] IR_DIV  = 32'h80000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_ILL  = 32'hB0000000;

  typedef struct {
    logic        clr;
    logic        mem;
    logic        stop;
    logic [31:0] ir;
    logic [24:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [24:0] sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic add(input logic clr, input logic mem, input logic stop,
                     input logic [31:0] ir, input logic [24:0] exp);
    vec_t v;
    v.clr = clr; v.mem = mem; v.stop = stop; v.ir = ir; v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic logic [24:0] snap();
    return {cu.PCout, cu.Zhighout, cu.Zlowout, cu.MDRout, cu.MARin, cu.PCin,
            cu.MDRin, cu.IRin, cu.Yin, cu.Zin, cu.HIin, cu.LOin, cu.IncPC,
            cu.Read, cu.Gra, cu.Grb, cu.Grc, cu.Rin, cu.Rout, cu.Run, cu.ALU_op};
  endfunction

  task automatic cycle();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic check_onehot(input int idx);
    int n;
    n = $countones({cu.PCout, cu.Zhighout, cu.Zlowout, cu.MDRout, cu.Rout});
    n_checks++;
    if (n > 1) begin
      n_fail++;
      $display("FAIL bus_onehot step=%0d sources_high=%0d allowed<=1", idx, n);
    end
  endtask

  task automatic check_out(input int idx);
    logic [24:0] act;
    logic [24:0] exp;
    act = snap();
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty step=%0d got=%h", idx, act);
    end else begin
      exp = sb_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL outputs step=%0d got=%h expected=%h", idx, act, exp);
      end
    end
    check_onehot(idx);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    int          cyc;
    int          t1_seen;
    int          read_n;
    int          irin_n;
    bit          done;
    logic [24:0] act;

    cu.IR = IR_AND; cu.MemRdy = 1'b1; cu.Stop = 1'b0; Clear = 1'b1;

    // AND R5,R2,R4 after a two-cycle clear
    add(1, 1, 0, IR_AND, E_RST);
    add(1, 1, 0, IR_AND, E_RST);
    add(0, 1, 0, IR_AND, E_T0);
    add(0, 1, 0, IR_AND, E_T1);
    add(0, 1, 0, IR_AND, E_T2);
    add(0, 1, 0, IR_AND, E_T3);
    add(0, 1, 0, IR_AND, E_T4 | 25'd3);
    add(0, 1, 0, IR_AND, E_T5A);
    add(0, 1, 0, IR_AND, E_T0);
    // MUL: LO then HI write-back
    add(0, 1, 0, IR_MUL, E_T1);
    add(0, 1, 0, IR_MUL, E_T2);
    add(0, 1, 0, IR_MUL, E_T3);
    add(0, 1, 0, IR_MUL, E_T4 | 25'd15);
    add(0, 1, 0, IR_MUL, E_T5H);
    add(0, 1, 0, IR_MUL, E_T6);
    add(0, 1, 0, IR_MUL, E_T0);
    // DIV
    add(0, 1, 0, IR_DIV, E_T1);
    add(0, 1, 0, IR_DIV, E_T2);
    add(0, 1, 0, IR_DIV, E_T3);
    add(0, 1, 0, IR_DIV, E_T4 | 25'd16);
    add(0, 1, 0, IR_DIV, E_T5H);
    add(0, 1, 0, IR_DIV, E_T6);
    add(0, 1, 0, IR_DIV, E_T0);
    // Illegal opcode and NOP fall straight back to fetch
    add(0, 1, 0, IR_ILL, E_T1);
    add(0, 1, 0, IR_ILL, E_T2);
    add(0, 1, 0, IR_ILL, E_T0);
    add(0, 1, 0, IR_NOP, E_T1);
    add(0, 1, 0, IR_NOP, E_T2);
    add(0, 1, 0, IR_NOP, E_T0);
    // Clear during T4
    add(0, 1, 0, IR_SUB, E_T1);
    add(0, 1, 0, IR_SUB, E_T2);
    add(0, 1, 0, IR_SUB, E_T3);
    add(0, 1, 0, IR_SUB, E_T4 | 25'd2);
    add(1, 1, 0, IR_SUB, E_RST);
    add(0, 1, 0, IR_SUB, E_T0);
    // Stop in T0 halts; Clear beats Stop
    add(0, 1, 1, IR_AND, E_HALT);
    add(0, 0, 0, IR_AND, E_HALT);
    add(1, 1, 1, IR_AND, E_RST);
    add(0, 1, 0, IR_AND, E_T0);
    // Stop raised mid-instruction only acts at the next T0
    add(0, 1, 0, IR_SHL, E_T1);
    add(0, 1, 1, IR_SHL, E_T2);
    add(0, 1, 1, IR_SHL, E_T3);
    add(0, 1, 1, IR_SHL, E_T4 | 25'd6);
    add(0, 1, 1, IR_SHL, E_T5A);
    add(0, 1, 1, IR_SHL, E_T0);
    add(0, 1, 1, IR_SHL, E_HALT);
    add(1, 1, 0, IR_SHL, E_RST);
    add(0, 1, 0, IR_SHL, E_T0);
    // HALT opcode: 20 quiet cycles, then Clear restarts
    add(0, 1, 0, IR_HALT, E_T1);
    add(0, 1, 0, IR_HALT, E_T2);
    add(0, 1, 0, IR_HALT, E_HALT);
    for (int k = 0; k < 20; k++) add(0, k[0], k[1], IR_HALT, E_HALT);
    add(1, 1, 0, IR_HALT, E_RST);
    add(0, 1, 0, IR_AND, E_T0);

    @(negedge Clock);
    foreach (vecs[i]) begin
      Clear     = vecs[i].clr;
      cu.MemRdy = vecs[i].mem;
      cu.Stop   = vecs[i].stop;
      cu.IR     = vecs[i].ir;
      sb_q.push_back(vecs[i].exp);
      cycle();
      check_out(i);
    end

    // Three memory wait cycles in T1: ALU instruction stretches to 9 cycles
    Clear = 1'b0; cu.Stop = 1'b0; cu.IR = IR_AND;
    cyc = 0; t1_seen = 0; read_n = 0; irin_n = 0; done = 1'b0;
    while (!done && cyc < 50) begin
      cu.MemRdy = (t1_seen >= 4);
      cycle();
      cyc++;
      act = snap();
      check_onehot(1000 + cyc);
      if (act == E_T1) t1_seen++;
      if (cu.Read) read_n++;
      if (cu.IRin) irin_n++;
      if (act == E_T0) done = 1'b1;
    end
    check_int("wait_reached_T0", int'(done), 1);
    check_int("wait_latency", cyc, 9);
    check_int("wait_read_cycles", read_n, 4);
    check_int("wait_mdrin_cycles", t1_seen, 4);
    check_int("wait_irin_pulses", irin_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
